// File: rtl/axis_fir_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// axis_fir_coeff_ctrl
// Run-time coefficient controller for the AXI4-Stream FIR filter.
// A coefficient frame arrives on the cfg_* AXI4-Stream port, tap 0 first, and
// is captured in a shadow bank. The frame length is checked. A frame of the
// correct length is copied to the active bank in one clock edge, on a cycle
// where the FIR pipeline does not advance. The cycle after that copy,
// coeff_update_o and flush_o pulse together so the FIR re-primes its delay line.
//
// Optional build macro: AXIS_FIR_COEFF_CSUM_EN
//   When defined, each frame carries one extra trailing checksum beat. The
//   checksum is the two's-complement negation of the tap sum, modulo 2^COEFF_W.
//   A checksum mismatch sets the sticky err_csum_o flag and the frame is dropped.
// -----------------------------------------------------------------------------
module axis_fir_coeff_ctrl #(
   parameter int NUM_TAPS = 8,
   parameter int COEFF_W  = 16,
   parameter int CNT_W    = 8
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic [COEFF_W-1:0]           cfg_tdata,
   input  logic                         cfg_tvalid,
   output logic                         cfg_tready,
   input  logic                         cfg_tlast,
   input  logic                         dp_advance_i,
   output logic [NUM_TAPS*COEFF_W-1:0]  coeff_o,
   output logic                         coeff_update_o,
   output logic                         flush_o,
   output logic                         busy_o,
   output logic                         err_short_o,
   output logic                         err_long_o,
`ifdef AXIS_FIR_COEFF_CSUM_EN
   output logic                         err_csum_o,
`endif
   input  logic                         err_clr_i,
   output logic [CNT_W-1:0]             commit_cnt_o
);

   localparam int IDX_W = $clog2(NUM_TAPS) + 1;
`ifdef AXIS_FIR_COEFF_CSUM_EN
   localparam int FRAME_LEN = NUM_TAPS + 1;
`else
   localparam int FRAME_LEN = NUM_TAPS;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0] TAP_LIM  = IDX_W'(NUM_TAPS);

   typedef logic [NUM_TAPS-1:0][COEFF_W-1:0] bank_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_COMMIT_WAIT
   } state_t;

   // Identity filter: tap 0 passes the sample through, all other taps are zero.
   function automatic bank_t identity_bank();
      bank_t b;
      b    = '0;
      b[0] = COEFF_W'(1);
      return b;
   endfunction

   localparam bank_t IDENTITY = identity_bank();

   state_t           state, state_next;
   logic [IDX_W-1:0] idx, idx_next;
   bank_t            shadow, active;
   logic             shadow_we;
   logic             commit;
   logic             set_short, set_long, set_csum;
   logic             pulse;
   logic             csum_ok;
   logic [CNT_W-1:0] commit_cnt;

`ifdef AXIS_FIR_COEFF_CSUM_EN
   logic [COEFF_W-1:0] csum_acc;
   logic [COEFF_W-1:0] csum_total;
   logic               err_csum;

   // The running sum plus the final beat must wrap to zero.
   assign csum_total = csum_acc + cfg_tdata;
   assign csum_ok    = (csum_total == '0);
`else
   assign csum_ok    = 1'b1;
`endif

   // State register and beat index.
   always_ff @(posedge ACLK) begin
      // NOTE: every clocked assignment is non-blocking. Then all registers
      // sample the same pre-edge values, whatever order the blocks run in.
      if (!ARESETn) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // Next-state logic: frame length checking, shadow write enable, commit.
   always_comb begin
      // NOTE: every output of this block gets a default first. Then no path
      // leaves a signal unassigned, so no latch is inferred.
      state_next = state;
      idx_next   = idx;
      cfg_tready = 1'b1;
      shadow_we  = 1'b0;
      commit     = 1'b0;
      set_short  = 1'b0;
      set_long   = 1'b0;
      set_csum   = 1'b0;
      unique case (state)
         S_IDLE: begin
            // idx is always 0 here, so this beat lands in shadow[0].
            if (cfg_tvalid) begin
               shadow_we = 1'b1;
               if (cfg_tlast) begin
                  set_short = 1'b1;
               end else begin
                  idx_next   = IDX_W'(1);
                  state_next = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (cfg_tvalid) begin
               // The checksum beat (index NUM_TAPS) is never stored.
               shadow_we = (idx < TAP_LIM);
               if (idx != LAST_IDX) begin
                  if (cfg_tlast) begin
                     set_short  = 1'b1;
                     idx_next   = '0;
                     state_next = S_IDLE;
                  end else begin
                     idx_next = idx + IDX_W'(1);
                  end
               end else begin
                  idx_next = '0;
                  if (!cfg_tlast) begin
                     set_long   = 1'b1;
                     state_next = S_DRAIN;
                  end else if (csum_ok) begin
                     state_next = S_COMMIT_WAIT;
                  end else begin
                     set_csum   = 1'b1;
                     state_next = S_IDLE;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (cfg_tvalid && cfg_tlast) begin
               state_next = S_IDLE;
            end
         end
         S_COMMIT_WAIT: begin
            // Hold the config port so the shadow bank stays stable until the
            // copy. Commit only on a cycle where the pipeline stalls.
            cfg_tready = 1'b0;
            if (!dp_advance_i) begin
               commit     = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Shadow capture, atomic shadow-to-active copy, commit counter and pulse.
   always_ff @(posedge ACLK) begin
      // NOTE: both banks are reset on purpose. After reset the active bank
      // must be the identity filter, and a reset mid-frame must discard any
      // partially written shadow contents.
      if (!ARESETn) begin
         shadow     <= IDENTITY;
         active     <= IDENTITY;
         commit_cnt <= '0;
         pulse      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            if (shadow_we && (idx == IDX_W'(i))) begin
               shadow[i] <= cfg_tdata;
            end
         end
         if (commit) begin
            active     <= shadow;
            commit_cnt <= commit_cnt + CNT_W'(1);
         end
         pulse <= commit;
      end
   end

   // Sticky error flags; a set in the same cycle as a clear wins.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         err_short_o <= 1'b0;
         err_long_o  <= 1'b0;
      end else begin
         err_short_o <= set_short | (err_short_o & ~err_clr_i);
         err_long_o  <= set_long  | (err_long_o  & ~err_clr_i);
      end
   end

`ifdef AXIS_FIR_COEFF_CSUM_EN
   // Running tap sum for the checksum and its sticky mismatch flag.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         csum_acc <= '0;
         err_csum <= 1'b0;
      end else begin
         if (cfg_tvalid && (state == S_IDLE)) begin
            csum_acc <= cfg_tdata;
         end else if (cfg_tvalid && (state == S_LOAD)) begin
            csum_acc <= csum_total;
         end
         err_csum <= set_csum | (err_csum & ~err_clr_i);
      end
   end

   assign err_csum_o = err_csum;
`endif

   assign coeff_o        = active;
   assign coeff_update_o = pulse;
   assign flush_o        = pulse;
   assign busy_o         = (state != S_IDLE);
   assign commit_cnt_o   = commit_cnt;

endmodule
